pdm_rx: RTL and testbench

PDM receiver and CIC decimator for a PDM MEMS microphone: the input counterpart of the on-chip PDM DAC. Generates the microphone bit clock from `clk` and captures the 1-bit stream on the selected channel edge. Decimates through a 4th-order CIC filter and emits signed PCM samples with a one-cycle valid strobe. With defaults at 48 MHz: `pdm_clk` is 3 MHz and the output rate is 46.875 kHz.

---
 rtl/pdm_pkg.sv | 37 +++
 rtl/pdm_rx_cic_decimator.sv | 97 +++++++++
 rtl/pdm_rx.sv | 75 +++++++
 tb/tb_pdm_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM audio paths (receiver and DAC).
//   CIC_ORDER   : number of integrator / comb stages in the CIC filters
//   cic_width() : internal CIC word width for a given log2 decimation ratio
//   sat_shift() : arithmetic right shift followed by saturation to out_w bits
package pdm_pkg;

  localparam int unsigned CIC_ORDER = 4;

  // Widest CIC word supported (DECIM_LOG2 = 8); sat_shift works at this width.
  localparam int unsigned SAT_W = CIC_ORDER * 8 + 2;
  typedef logic signed [SAT_W-1:0] sat_t;

  // Capture point within a pdm_clk period.
  typedef enum logic {
    CAP_LOW_END  = 1'b0,  // last cycle of the low phase, just before pdm_clk rises
    CAP_HIGH_END = 1'b1   // last cycle of the high phase, just before pdm_clk falls
  } cap_edge_e;

  function automatic int unsigned cic_width(input int unsigned decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

  // Result is sign-extended to SAT_W; callers keep the low out_w bits.
  function automatic sat_t sat_shift(input sat_t x, input int unsigned shift,
                                     input int unsigned out_w);
    sat_t s;
    sat_t hi;
    sat_t lo;
    s  = x >>> shift;
    hi = (sat_t'(1) <<< (out_w - 1)) - sat_t'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/pdm_rx_cic_decimator.sv
// 4th-order CIC decimator with pipelined combs and saturating output scaling.
//   clk, rst      : system clock, asynchronous active-low reset
//   enable        : low synchronously clears the filter (sample is held)
//   bit_valid     : one-cycle strobe, bit_in is a new PDM bit
//   bit_in        : PDM bit (1 -> +1, 0 -> -1)
//   sample        : signed PCM sample, updated only with sample_valid
//   sample_valid  : one-cycle strobe per R input bits
module cic_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM_LOG2   = 6,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           bit_valid,
  input  logic                           bit_in,
  output logic signed [OUTPUT_WIDTH-1:0] sample,
  output logic                           sample_valid
);

  localparam int unsigned W     = cic_width(DECIM_LOG2);
  localparam int unsigned SHIFT = CIC_ORDER * DECIM_LOG2 + 1 - OUTPUT_WIDTH;

  localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
  localparam logic signed [W-1:0] MINUS_ONE = '1;

  logic signed [W-1:0]     integ   [CIC_ORDER];
  logic signed [W-1:0]     comb    [CIC_ORDER];
  logic signed [W-1:0]     delay   [CIC_ORDER];
  logic [CIC_ORDER-1:0]    comb_v;
  logic [DECIM_LOG2-1:0]   dec_cnt;
  logic                    tick;
  logic signed [W-1:0]     x_in;

  assign x_in = bit_in ? PLUS_ONE : MINUS_ONE;

  // Integrators and decimation counter, advancing once per input bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
      dec_cnt <= '0;
      tick    <= 1'b0;
    end else if (!enable) begin
      for (int unsigned k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
      dec_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (bit_valid) begin
        integ[0] <= integ[0] + x_in;
        for (int unsigned k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        dec_cnt <= dec_cnt + 1'b1;
        // Counter wraps at R naturally; the all-ones value marks the R-th bit.
        tick    <= &dec_cnt;
      end
    end
  end

  // Comb pipeline: one stage per clk, each stage's history updated only when
  // its input carries a decimated value. Output register follows stage 4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < CIC_ORDER; k++) begin
        comb[k]  <= '0;
        delay[k] <= '0;
      end
      comb_v       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else if (!enable) begin
      for (int unsigned k = 0; k < CIC_ORDER; k++) begin
        comb[k]  <= '0;
        delay[k] <= '0;
      end
      comb_v       <= '0;
      sample_valid <= 1'b0;
    end else begin
      comb_v <= {comb_v[CIC_ORDER-2:0], tick};
      if (tick) begin
        comb[0]  <= integ[CIC_ORDER-1] - delay[0];
        delay[0] <= integ[CIC_ORDER-1];
      end
      for (int unsigned k = 1; k < CIC_ORDER; k++) begin
        if (comb_v[k-1]) begin
          comb[k]  <= comb[k-1] - delay[k];
          delay[k] <= comb[k-1];
        end
      end
      sample_valid <= comb_v[CIC_ORDER-1];
      if (comb_v[CIC_ORDER-1])
        sample <= OUTPUT_WIDTH'(sat_shift(sat_t'(comb[CIC_ORDER-1]), SHIFT, OUTPUT_WIDTH));
    end
  end

endmodule

// File: rtl/pdm_rx.sv
// PDM microphone receiver: bit-clock generation, input synchronizer, capture
// strobe, and a CIC decimator producing signed PCM samples.
//   clk, rst      : system clock, asynchronous active-low reset
//   enable        : run; low holds pdm_clk at 0 and clears the datapath
//   pdm_clk       : microphone bit clock (CLK_DIV clk cycles per period)
//   pdm_data      : microphone data, asynchronous to clk
//   sample        : signed PCM sample
//   sample_valid  : one-cycle strobe marking a new sample
module pdm_rx
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned DECIM_LOG2   = 6,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned CHANNEL_EDGE = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  output logic                           pdm_clk,
  input  logic                           pdm_data,
  output logic signed [OUTPUT_WIDTH-1:0] sample,
  output logic                           sample_valid
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam cap_edge_e     EDGE = (CHANNEL_EDGE == 0) ? CAP_LOW_END : CAP_HIGH_END;
  localparam logic [CW-1:0] CAP  = (EDGE == CAP_LOW_END) ? LAST : CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    sync;
  logic          bit_valid;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // pdm_clk is decoded from the next count so the register lines up with cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pdm_clk <= 1'b0;
      sync    <= '0;
    end else begin
      sync <= {sync[0], pdm_data};
      if (!enable) begin
        cnt     <= '0;
        pdm_clk <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        pdm_clk <= (cnt_nxt < HALF);
      end
    end
  end

  // The first integrator stage registers the synchronized bit on this strobe.
  assign bit_valid = enable && (cnt == CAP);

  cic_decimator #(
    .DECIM_LOG2  (DECIM_LOG2),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_cic (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bit_valid   (bit_valid),
    .bit_in      (sync[1]),
    .sample      (sample),
    .sample_valid(sample_valid)
  );

endmodule

// File: tb/tb_pdm_rx.sv
// Bench for pdm_rx: two instances (capture at end of low phase / high phase)
// fed by behavioural microphones; expected samples queued per scenario.
module tb_pdm_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic pdm_clk0, pdm_clk1;
  logic pdm_data0 = 1'b0;
  logic pdm_data1 = 1'b0;
  logic signed [15:0] sample0, sample1;
  logic sv0, sv1;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  logic [3:0] pat = 4'b1111;
  logic [1:0] idx = 2'd0;
  bit edge_mode = 1'b0;

  int q0[$];
  int q1[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pdm_rx #(.CLK_DIV(16), .DECIM_LOG2(6), .OUTPUT_WIDTH(16), .CHANNEL_EDGE(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .pdm_clk(pdm_clk0), .pdm_data(pdm_data0),
    .sample(sample0), .sample_valid(sv0));

  pdm_rx #(.CLK_DIV(16), .DECIM_LOG2(6), .OUTPUT_WIDTH(16), .CHANNEL_EDGE(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .pdm_clk(pdm_clk1), .pdm_data(pdm_data1),
    .sample(sample1), .sample_valid(sv1));

  // Microphone: in pattern mode a new bit follows each falling edge; in edge
  // mode the data line mirrors the clock phase (1 while high, 0 while low).
  always @(pdm_clk0) begin
    #2;
    if (edge_mode) pdm_data0 = pdm_clk0;
    else if (!pdm_clk0) begin
      pdm_data0 = pat[idx];
      idx = idx + 2'd1;
    end
  end

  always @(pdm_clk1) begin
    #2;
    pdm_data1 = edge_mode ? pdm_clk1 : pdm_data0;
  end

  task automatic wait_valid(input bit sel, output logic signed [15:0] val,
                            output longint stamp, output bit ok);
    ok = 1'b0;
    val = '0;
    stamp = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ((sel ? sv1 : sv0) === 1'b1) begin
        val = sel ? sample1 : sample0;
        stamp = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic restart(input logic [3:0] p, input bit em);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    pat = p;
    idx = 2'd0;
    edge_mode = em;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pdm_clk0 !== 1'b0) begin failures++; $display("FAIL reset_pdm_clk0 got=%b exp=0", pdm_clk0); end
    checks++; if (sample0 !== 16'sd0) begin failures++; $display("FAIL reset_sample0 got=%0d exp=0", sample0); end
    checks++; if (sv0 !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%b exp=0", sv0); end
    checks++; if (pdm_clk1 !== 1'b0) begin failures++; $display("FAIL reset_pdm_clk1 got=%b exp=0", pdm_clk1); end
    checks++; if (sample1 !== 16'sd0) begin failures++; $display("FAIL reset_sample1 got=%0d exp=0", sample1); end
    checks++; if (sv1 !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", sv1); end
    rst = 1'b1;
  endtask

  task automatic test_const_one();
    logic signed [15:0] v;
    longint st, prev;
    bit ok;
    restart(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) q0.push_back(32767);
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      wait_valid(1'b0, v, st, ok);
      if (!ok) begin checks++; failures++; $display("FAIL const_one_timeout got=none exp=valid"); break; end
      if (i >= 4) begin
        checks++;
        if (v !== 16'(q0.pop_front())) begin failures++; $display("FAIL const_one_sample got=%0d exp=32767", v); end
        checks++;
        if (st - prev != 1024) begin failures++; $display("FAIL const_one_spacing got=%0d exp=1024", st - prev); end
      end
      prev = st;
    end
  endtask

  task automatic test_const_zero();
    logic signed [15:0] v;
    longint st;
    bit ok;
    restart(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) q0.push_back(-32768);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid(1'b0, v, st, ok);
      if (!ok) begin checks++; failures++; $display("FAIL const_zero_timeout got=none exp=valid"); break; end
      if (i >= 4) begin
        checks++;
        if (v !== 16'(q0.pop_front())) begin failures++; $display("FAIL const_zero_sample got=%0d exp=-32768", v); end
      end
    end
  endtask

  task automatic test_alternating();
    logic signed [15:0] v;
    longint st;
    bit ok;
    restart(4'b0101, 1'b0);
    for (int i = 0; i < 3; i++) q0.push_back(0);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid(1'b0, v, st, ok);
      if (!ok) begin checks++; failures++; $display("FAIL alternating_timeout got=none exp=valid"); break; end
      if (i >= 4) begin
        checks++;
        if (v !== 16'(q0.pop_front())) begin failures++; $display("FAIL alternating_sample got=%0d exp=0", v); end
      end
    end
  endtask

  task automatic test_quarter_density();
    logic signed [15:0] v;
    longint st;
    bit ok;
    logic [3:0] pats [2];
    int exps [2];
    pats[0] = 4'b0111; exps[0] = 16384;   // 1,1,1,0
    pats[1] = 4'b0001; exps[1] = -16384;  // 1,0,0,0
    for (int p = 0; p < 2; p++) begin
      restart(pats[p], 1'b0);
      for (int i = 0; i < 3; i++) q0.push_back(exps[p]);
      enable = 1'b1;
      for (int i = 0; i < 7; i++) begin
        wait_valid(1'b0, v, st, ok);
        if (!ok) begin checks++; failures++; $display("FAIL quarter_timeout pattern=%0d got=none exp=valid", p); break; end
        if (i >= 4) begin
          checks++;
          if (v !== 16'(q0.pop_front())) begin
            failures++; $display("FAIL quarter_sample pattern=%0d got=%0d exp=%0d", p, v, exps[p]);
          end
        end
      end
    end
  endtask

  task automatic test_channel_edge();
    logic signed [15:0] v;
    longint st;
    bit ok;
    restart(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      q0.push_back(-32768);
      q1.push_back(32767);
    end
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_valid(1'b1, v, st, ok);
      if (!ok) begin checks++; failures++; $display("FAIL edge_high_timeout got=none exp=valid"); break; end
      if (i >= 4) begin
        checks++;
        if (v !== 16'(q1.pop_front())) begin failures++; $display("FAIL edge_high_sample got=%0d exp=32767", v); end
      end
      wait_valid(1'b0, v, st, ok);
      if (!ok) begin checks++; failures++; $display("FAIL edge_low_timeout got=none exp=valid"); break; end
      if (i >= 4) begin
        checks++;
        if (v !== 16'(q0.pop_front())) begin failures++; $display("FAIL edge_low_sample got=%0d exp=-32768", v); end
      end
    end
  endtask

  // Follows test_const_one, so the held sample is the saturated positive value.
  task automatic test_enable_gap();
    int bad_clk, bad_valid, bad_hold;
    bad_clk = 0; bad_valid = 0; bad_hold = 0;
    @(negedge clk);
    enable = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (pdm_clk0 !== 1'b0) bad_clk++;
      if (sv0 !== 1'b0) bad_valid++;
      if (sample0 !== 16'sd32767) bad_hold++;
    end
    checks++; if (bad_clk != 0) begin failures++; $display("FAIL gap_pdm_clk got=%0d_high_cycles exp=0", bad_clk); end
    checks++; if (bad_valid != 0) begin failures++; $display("FAIL gap_valid got=%0d_strobes exp=0", bad_valid); end
    checks++; if (bad_hold != 0) begin failures++; $display("FAIL gap_hold got=%0d_changed_cycles exp=0 last=%0d", bad_hold, sample0); end
  endtask

  task automatic test_reset_restart();
    int bad_clk, bad_out, n;
    bad_clk = 0; bad_out = 0;
    restart(4'b1111, 1'b0);
    enable = 1'b1;
    repeat (2500) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (pdm_clk0 !== 1'b0) begin failures++; $display("FAIL rst_pdm_clk got=%b exp=0", pdm_clk0); end
    checks++; if (sample0 !== 16'sd0) begin failures++; $display("FAIL rst_sample got=%0d exp=0", sample0); end
    checks++; if (sv0 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", sv0); end
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (pdm_clk0 !== 1'b0) bad_clk++;
      if (sample0 !== 16'sd0 || sv0 !== 1'b0) bad_out++;
    end
    checks++; if (bad_clk != 0) begin failures++; $display("FAIL rst_gap_pdm_clk got=%0d_high_cycles exp=0", bad_clk); end
    checks++; if (bad_out != 0) begin failures++; $display("FAIL rst_gap_outputs got=%0d_bad_cycles exp=0", bad_out); end
    enable = 1'b1;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (sv0 === 1'b1) break;
    end
    checks++; if (n != 1029) begin failures++; $display("FAIL restart_latency got=%0d exp=1029", n); end
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_enable_gap();
    test_const_zero();
    test_alternating();
    test_quarter_density();
    test_channel_edge();
    test_reset_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
